ram_march_bist: RTL and testbench
=================================

Name: ram_march_bist

Overview:
- Single-clock March C- built-in self-test engine for the team's synchronous RAMs.
- Sits directly upstream of one RAM port and drives its write-enable, address and write-data. It consumes that port's registered read data.
- Reports pass/fail, plus the first failing address, the expected word and the actual word.
- Used at bring-up and in regression to qualify each memory instance before functional traffic is muxed onto the port.

Parameters:
- DATA, 4, word width in bits; must match the RAM under test.
- DEPTH, 16, number of words; power of two, at least 2.
- ADDR, $clog2(DEPTH), address width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  begin a test run; sampled only while idle.
- mem_we  output  1  write enable to the RAM port.
- mem_addr  output  ADDR  address to the RAM port.
- mem_wdata  output  DATA  write data to the RAM port.
- mem_rdata  input  DATA  RAM read data, valid one cycle after the read address is presented.
- busy  output  1  a test run is in progress.
- done  output  1  run finished; held until the next accepted start or reset.
- fail  output  1  a mismatch was found; valid when done=1.
- fail_addr  output  ADDR  address of the first mismatch.
- fail_exp  output  DATA  expected word at the first mismatch.
- fail_act  output  DATA  actual word at the first mismatch.

Behaviour:
- Interface: one clock (clk); synchronous active-low reset (rst_n).
- Reset values: all outputs 0 and the state machine is IDLE. Reset is sampled on the clk edge and is honoured in every state, including mid-run. A mid-run reset aborts the run with no done pulse, and mem_we is 0 from the next cycle.
- Output timing: all memory-side outputs are registered. The RAM sees an operation presented in cycle k at the edge ending cycle k, so read data for a read in cycle k is compared at the edge ending cycle k+1.
- Test patterns: P0 is all zeros; P1 is all ones ({DATA{1'b1}}).
- Sequence (up = address 0 to DEPTH-1, down = DEPTH-1 to 0):
  - M0: up, w P0.
  - M1: up, r P0 then w P1.
  - M2: up, r P1 then w P0.
  - M3: down, r P0 then w P1.
  - M4: down, r P1 then w P0.
  - M5: up, r P0.
- States: IDLE, M0_W, RD, WR, M5_RD, M5_LAST, DONE.
- IDLE: busy=0, mem_we=0. If start=1, move to M0_W: address 0, busy=1, and done, fail and the fail_* registers are cleared.
- M0_W: one write per cycle with mem_wdata=P0. After address DEPTH-1, go to RD for M1 at address 0.
- RD (M1-M4):
  - mem_we=0, mem_addr=current address.
  - Always go to WR at the same address.
- WR (M1-M4):
  - mem_we=1, mem_wdata = that element's write pattern.
  - In the same cycle, compare mem_rdata with the element's read pattern.
  - On a mismatch, store fail_addr, fail_exp and fail_act, set fail=1 and go to DONE. The write is still issued; the run then stops.
  - Otherwise advance the address in the element's direction and go to RD.
  - At the element's end address, switch elements: M2 and M3 start at the other end, so M3 starts at DEPTH-1 and M4 at DEPTH-1; after M4, go to M5_RD at address 0.
- M5_RD: read one address per cycle. Each cycle (except the first) compares mem_rdata with P0 for the previous address. After address DEPTH-1, go to M5_LAST.
- M5_LAST: mem_we=0 and compare for address DEPTH-1, then go to DONE.
- Any mismatch goes to DONE with the first failure captured.
- DONE: busy=0, done=1, mem_we=0. Another start=1 restarts the run with the same clearing as from IDLE.
- Run length: a fault-free run keeps busy=1 for exactly 10*DEPTH+1 cycles (161 at defaults). done rises on the following cycle.
- start while busy=1 is ignored.
- Address arithmetic wraps modulo DEPTH, but the end of each element is detected explicitly, never by wrap.

Test Plan:
- Fault-free RAM model with 1-cycle registered read, start pulsed once -> busy high 161 cycles; then done=1, fail=0, fail_addr=0, fail_exp=0, fail_act=0.
- Bit 0 of address 0 stuck at 1 -> first M1 read fails; done=1, fail=1, fail_addr=0, fail_exp=4'h0, fail_act=4'h1.
- Bit 2 of address 5 stuck at 0 -> fails in M2; fail_addr=5, fail_exp=4'hF, fail_act=4'hB.
- Address decoder fault, address 15 aliases to 14 -> fails in M1 at address 15; fail_exp=4'h0, fail_act=4'hF.
- rst_n low for one cycle at cycle 50 of a run -> next cycle busy=0, done=0, mem_we=0. A new start then completes a clean 161-cycle run.
- start held high throughout a run -> no restart while busy. After completion, done=1 for exactly one cycle, then a new run begins and done and fail clear.

Source files
------------

// File: rtl/ram_march_bist.sv
// March C- self-test engine for one synchronous RAM port.
// Drives registered we/addr/wdata and checks the RAM's one-cycle-late read data.
module ram_march_bist #(
  parameter int DATA  = 4,
  parameter int DEPTH = 16,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_wdata,
  input  logic [DATA-1:0] mem_rdata,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic [ADDR-1:0] fail_addr,
  output logic [DATA-1:0] fail_exp,
  output logic [DATA-1:0] fail_act
);

  typedef enum logic [2:0] {
    IDLE, M0_W, RD, WR, M5_RD, M5_LAST, DONE
  } state_t;

  localparam logic [DATA-1:0] P0   = '0;
  localparam logic [DATA-1:0] P1   = '1;
  localparam logic [ADDR-1:0] LAST = ADDR'(DEPTH - 1);
  localparam logic [ADDR-1:0] ONE  = ADDR'(1);

  state_t          state, state_d;
  // elem selects the read/write element: 0..3 map to M1..M4
  logic [1:0]      elem, elem_d;
  logic [ADDR-1:0] addr_d;
  logic            we_d;
  logic [DATA-1:0] wdata_d;
  logic            fail_d;
  logic [ADDR-1:0] fail_addr_d;
  logic [DATA-1:0] fail_exp_d, fail_act_d;
  logic [DATA-1:0] rd_pat, wr_pat;
  logic            up;
  logic [ADDR-1:0] end_addr;

  always_comb begin
    rd_pat   = elem[0] ? P1 : P0;
    wr_pat   = elem[0] ? P0 : P1;
    up       = ~elem[1];
    end_addr = up ? LAST : '0;
  end

  always_comb begin
    state_d     = state;
    elem_d      = elem;
    addr_d      = mem_addr;
    we_d        = 1'b0;
    wdata_d     = mem_wdata;
    fail_d      = fail;
    fail_addr_d = fail_addr;
    fail_exp_d  = fail_exp;
    fail_act_d  = fail_act;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d     = M0_W;
          elem_d      = 2'd0;
          addr_d      = '0;
          we_d        = 1'b1;
          wdata_d     = P0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_act_d  = '0;
        end
      end

      M0_W: begin
        if (mem_addr == LAST) begin
          state_d = RD;
          elem_d  = 2'd0;
          addr_d  = '0;
        end else begin
          addr_d  = mem_addr + ONE;
          we_d    = 1'b1;
          wdata_d = P0;
        end
      end

      RD: begin
        state_d = WR;
        we_d    = 1'b1;
        wdata_d = wr_pat;
      end

      // Read data for this address arrives while its write is being issued
      WR: begin
        if (mem_rdata != rd_pat) begin
          state_d     = DONE;
          fail_d      = 1'b1;
          fail_addr_d = mem_addr;
          fail_exp_d  = rd_pat;
          fail_act_d  = mem_rdata;
        end else if (mem_addr == end_addr) begin
          unique case (elem)
            2'd0: begin state_d = RD;    elem_d = 2'd1; addr_d = '0;   end
            2'd1: begin state_d = RD;    elem_d = 2'd2; addr_d = LAST; end
            2'd2: begin state_d = RD;    elem_d = 2'd3; addr_d = LAST; end
            2'd3: begin state_d = M5_RD; addr_d = '0;                  end
          endcase
        end else begin
          state_d = RD;
          addr_d  = up ? mem_addr + ONE : mem_addr - ONE;
        end
      end

      // Data seen here belongs to the address presented one cycle earlier
      M5_RD: begin
        if ((mem_addr != '0) && (mem_rdata != P0)) begin
          state_d     = DONE;
          fail_d      = 1'b1;
          fail_addr_d = mem_addr - ONE;
          fail_exp_d  = P0;
          fail_act_d  = mem_rdata;
        end else if (mem_addr == LAST) begin
          state_d = M5_LAST;
        end else begin
          addr_d = mem_addr + ONE;
        end
      end

      M5_LAST: begin
        state_d = DONE;
        if (mem_rdata != P0) begin
          fail_d      = 1'b1;
          fail_addr_d = LAST;
          fail_exp_d  = P0;
          fail_act_d  = mem_rdata;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      elem      <= 2'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
    end else begin
      state     <= state_d;
      elem      <= elem_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      busy      <= (state_d != IDLE) && (state_d != DONE);
      done      <= (state_d == DONE);
      fail      <= fail_d;
      fail_addr <= fail_addr_d;
      fail_exp  <= fail_exp_d;
      fail_act  <= fail_act_d;
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: a 16x4 RAM model with selectable faults,
// a table of fault scenarios, and hand sequences for reset and held start.
module tb_ram_march_bist;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;
  logic       busy;
  logic       done;
  logic       fail;
  logic [3:0] fail_addr;
  logic [3:0] fail_exp;
  logic [3:0] fail_act;

  int compared   = 0;
  int mismatched = 0;

  ram_march_bist #(.DATA(4), .DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_exp  (fail_exp),
    .fail_act  (fail_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fault modes: 0 none, 1 read bits stuck at 1, 2 read bits stuck at 0,
  // 3 faddr aliases to faddr-1, 4 cell cannot fall from F to 0, 5 fifth write lost
  int         fmode;
  logic [3:0] faddr;
  logic [3:0] fmask;
  logic [3:0] mem [16];
  int         wcnt [16];
  logic [3:0] ea;
  logic [3:0] rv;
  logic       ign;

  assign ea = (fmode == 3 && mem_addr == faddr) ? faddr - 4'd1 : mem_addr;

  always_comb begin
    rv = mem[ea];
    if (fmode == 1 && ea == faddr) rv = rv | fmask;
    if (fmode == 2 && ea == faddr) rv = rv & ~fmask;
  end

  always_comb begin
    ign = 1'b0;
    if (fmode == 4 && ea == faddr && mem_wdata == 4'h0 && mem[ea] == 4'hF) ign = 1'b1;
    if (fmode == 5 && ea == faddr && wcnt[ea] == 4) ign = 1'b1;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem[i]  <= 4'hA;
        wcnt[i] <= 0;
      end
    end else begin
      if (mem_we) begin
        if (!ign) mem[ea] <= mem_wdata;
        wcnt[ea] <= wcnt[ea] + 1;
      end
    end
    mem_rdata <= rv;
  end

  typedef struct {
    string      name;
    int         mode;
    logic [3:0] faddr;
    logic [3:0] fmask;
    int         exp_busy;
    logic       exp_fail;
    logic [3:0] exp_addr;
    logic [3:0] exp_exp;
    logic [3:0] exp_act;
  } vec_t;

  vec_t vecs [8];

  task automatic applyStimulus(input logic s, input logic r);
    @(negedge clk);
    start = s;
    rst_n = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
  endtask

  // Count busy cycles until busy drops, bounded so a stuck run still ends
  task automatic countBusy(output int cycles);
    cycles = 0;
    while (busy && cycles < 2000) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic runOnce(output int cycles);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    countBusy(cycles);
  endtask

  int cycles;

  initial begin
    start = 1'b0;
    rst_n = 1'b0;
    fmode = 0;
    faddr = 4'h0;
    fmask = 4'h0;

    vecs[0] = '{"clean",        0, 4'h0, 4'h0, 161, 1'b0, 4'h0, 4'h0, 4'h0};
    vecs[1] = '{"a0_b0_sa1",    1, 4'h0, 4'h1,  18, 1'b1, 4'h0, 4'h0, 4'h1};
    vecs[2] = '{"a5_b2_sa0",    2, 4'h5, 4'h4,  60, 1'b1, 4'h5, 4'hF, 4'hB};
    vecs[3] = '{"a15_alias14",  3, 4'hF, 4'h0,  48, 1'b1, 4'hF, 4'h0, 4'hF};
    vecs[4] = '{"a7_b3_sa1",    1, 4'h7, 4'h8,  32, 1'b1, 4'h7, 4'h0, 4'h8};
    vecs[5] = '{"a9_nofall",    4, 4'h9, 4'h0,  94, 1'b1, 4'h9, 4'h0, 4'hF};
    vecs[6] = '{"a12_lost_wr5", 5, 4'hC, 4'h0, 158, 1'b1, 4'hC, 4'h0, 4'hF};
    vecs[7] = '{"a15_lost_wr5", 5, 4'hF, 4'h0, 161, 1'b1, 4'hF, 4'h0, 4'hF};

    resetDut();
    checkOutput("reset_busy",      32'(busy),      32'h0);
    checkOutput("reset_done",      32'(done),      32'h0);
    checkOutput("reset_fail",      32'(fail),      32'h0);
    checkOutput("reset_we",        32'(mem_we),    32'h0);
    checkOutput("reset_addr",      32'(mem_addr),  32'h0);
    checkOutput("reset_wdata",     32'(mem_wdata), 32'h0);
    checkOutput("reset_fail_addr", 32'(fail_addr), 32'h0);
    checkOutput("reset_fail_exp",  32'(fail_exp),  32'h0);
    checkOutput("reset_fail_act",  32'(fail_act),  32'h0);

    for (int v = 0; v < 8; v++) begin
      fmode = vecs[v].mode;
      faddr = vecs[v].faddr;
      fmask = vecs[v].fmask;
      resetDut();
      runOnce(cycles);
      checkOutput({vecs[v].name, "_busy_cycles"}, 32'(cycles),    32'(vecs[v].exp_busy));
      checkOutput({vecs[v].name, "_done"},        32'(done),      32'h1);
      checkOutput({vecs[v].name, "_we"},          32'(mem_we),    32'h0);
      checkOutput({vecs[v].name, "_fail"},        32'(fail),      32'(vecs[v].exp_fail));
      checkOutput({vecs[v].name, "_fail_addr"},   32'(fail_addr), 32'(vecs[v].exp_addr));
      checkOutput({vecs[v].name, "_fail_exp"},    32'(fail_exp),  32'(vecs[v].exp_exp));
      checkOutput({vecs[v].name, "_fail_act"},    32'(fail_act),  32'(vecs[v].exp_act));
    end

    // Mid-run reset at cycle 50, then a clean rerun
    fmode = 0;
    resetDut();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    repeat (49) @(negedge clk);
    checkOutput("midrst_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy",  32'(busy),   32'h0);
    checkOutput("midrst_done",  32'(done),   32'h0);
    checkOutput("midrst_we",    32'(mem_we), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_idle_done", 32'(done), 32'h0);
    runOnce(cycles);
    checkOutput("rerun_busy_cycles", 32'(cycles), 32'd161);
    checkOutput("rerun_done",        32'(done),   32'h1);
    checkOutput("rerun_fail",        32'(fail),   32'h0);

    // Leave a failing result, then hold start high across a clean run
    fmode = 1;
    faddr = 4'h0;
    fmask = 4'h1;
    resetDut();
    runOnce(cycles);
    checkOutput("pre_hold_fail", 32'(fail), 32'h1);
    fmode = 0;
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    checkOutput("hold_fail_cleared", 32'(fail), 32'h0);
    checkOutput("hold_done_cleared", 32'(done), 32'h0);
    countBusy(cycles);
    checkOutput("hold_busy_cycles", 32'(cycles), 32'd161);
    checkOutput("hold_done",        32'(done),   32'h1);
    checkOutput("hold_fail",        32'(fail),   32'h0);
    @(negedge clk);
    checkOutput("hold_restart_busy", 32'(busy), 32'h1);
    checkOutput("hold_restart_done", 32'(done), 32'h0);
    start = 1'b0;
    resetDut();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
